// File: rtl/ip_sdram_arbiter.sv
// Purpose : sole master of the SDRAM controller bus; arbitrates VDP (read) and CPU (read/write), injects refresh.
// Latency : grant -> bus_valid/x_ready next cycle; bus_rdata_en -> x_rdata_en next cycle.
// Backpres: bus_* held stable until bus_ready; one transaction outstanding, clients wait for x_ready.
//
// Ports:
//   clk, reset_n (sync, active low), sdram_init_busy
//   vdp_address/vdp_valid -> vdp_ready, vdp_rdata, vdp_rdata_en
//   cpu_address/cpu_valid/cpu_write/cpu_wdata -> cpu_ready, cpu_rdata, cpu_rdata_en
//   bus_address/bus_valid/bus_write/bus_refresh/bus_wdata <- bus_ready, bus_rdata, bus_rdata_en
module ip_sdram_arbiter #(
    parameter int REFRESH_INTERVAL = 1280,
    parameter int RD_TIMEOUT       = 32,
    parameter int CPU_MAX_WAIT     = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        sdram_init_busy,
    input  logic [22:0] vdp_address,
    input  logic        vdp_valid,
    output logic        vdp_ready,
    output logic [15:0] vdp_rdata,
    output logic        vdp_rdata_en,
    input  logic [22:0] cpu_address,
    input  logic        cpu_valid,
    input  logic        cpu_write,
    input  logic [7:0]  cpu_wdata,
    output logic        cpu_ready,
    output logic [15:0] cpu_rdata,
    output logic        cpu_rdata_en,
    output logic [22:0] bus_address,
    output logic        bus_valid,
    input  logic        bus_ready,
    output logic        bus_write,
    output logic        bus_refresh,
    output logic [7:0]  bus_wdata,
    input  logic [15:0] bus_rdata,
    input  logic        bus_rdata_en
);

    localparam int RC_W = $clog2(REFRESH_INTERVAL);
    localparam int TO_W = $clog2(RD_TIMEOUT + 1);
    localparam int WC_W = $clog2(CPU_MAX_WAIT + 1);

    typedef enum logic [1:0] {ST_INIT, ST_IDLE, ST_ISSUE, ST_RDWAIT} state_t;

    state_t          state_q, state_d;
    logic [RC_W-1:0] ref_cnt_q, ref_cnt_d;
    logic [1:0]      ref_pend_q, ref_pend_d;
    logic [WC_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            owner_cpu_q, owner_cpu_d;
    logic [22:0]     bus_address_q, bus_address_d;
    logic            bus_valid_q, bus_valid_d;
    logic            bus_write_q, bus_write_d;
    logic            bus_refresh_q, bus_refresh_d;
    logic [7:0]      bus_wdata_q, bus_wdata_d;
    logic            vdp_ready_q, vdp_ready_d;
    logic            cpu_ready_q, cpu_ready_d;
    logic [15:0]     vdp_rdata_q, vdp_rdata_d;
    logic            vdp_rdata_en_q, vdp_rdata_en_d;
    logic [15:0]     cpu_rdata_q, cpu_rdata_d;
    logic            cpu_rdata_en_q, cpu_rdata_en_d;

    logic ref_tick;
    logic ref_acc;
    logic grant_ref;
    logic grant_vdp;
    logic grant_cpu;

    always_comb begin
        state_d        = state_q;
        ref_cnt_d      = ref_cnt_q;
        ref_pend_d     = ref_pend_q;
        wait_cnt_d     = wait_cnt_q;
        to_cnt_d       = to_cnt_q;
        owner_cpu_d    = owner_cpu_q;
        bus_address_d  = bus_address_q;
        bus_valid_d    = bus_valid_q;
        bus_write_d    = bus_write_q;
        bus_refresh_d  = bus_refresh_q;
        bus_wdata_d    = bus_wdata_q;
        vdp_ready_d    = 1'b0;
        cpu_ready_d    = 1'b0;
        vdp_rdata_d    = vdp_rdata_q;
        vdp_rdata_en_d = 1'b0;
        cpu_rdata_d    = cpu_rdata_q;
        cpu_rdata_en_d = 1'b0;
        grant_ref      = 1'b0;
        grant_vdp      = 1'b0;
        grant_cpu      = 1'b0;

        // Refresh timer is frozen while the controller is still initialising.
        ref_tick = (state_q != ST_INIT) && (ref_cnt_q == '0);
        ref_acc  = (state_q == ST_ISSUE) && bus_ready && bus_refresh_q;
        if (state_q != ST_INIT) begin
            ref_cnt_d = ref_tick ? RC_W'(REFRESH_INTERVAL - 1) : ref_cnt_q - 1'b1;
        end
        // A tick and an accept in the same cycle cancel out.
        if (ref_tick && !ref_acc && (ref_pend_q != 2'd3)) begin
            ref_pend_d = ref_pend_q + 2'd1;
        end else if (!ref_tick && ref_acc && (ref_pend_q != 2'd0)) begin
            ref_pend_d = ref_pend_q - 2'd1;
        end

        case (state_q)
            ST_INIT: begin
                if (!sdram_init_busy) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                // Backlogged refresh first, then a starved CPU, then VDP, CPU, lone refresh.
                if (ref_pend_q >= 2'd2) begin
                    grant_ref = 1'b1;
                end else if (cpu_valid && (wait_cnt_q == WC_W'(CPU_MAX_WAIT))) begin
                    grant_cpu = 1'b1;
                end else if (vdp_valid) begin
                    grant_vdp = 1'b1;
                end else if (cpu_valid) begin
                    grant_cpu = 1'b1;
                end else if (ref_pend_q == 2'd1) begin
                    grant_ref = 1'b1;
                end

                if (grant_ref) begin
                    state_d       = ST_ISSUE;
                    bus_valid_d   = 1'b1;
                    bus_refresh_d = 1'b1;
                    bus_write_d   = 1'b0;
                    bus_address_d = '0;
                    bus_wdata_d   = '0;
                end else if (grant_vdp) begin
                    state_d       = ST_ISSUE;
                    bus_valid_d   = 1'b1;
                    bus_refresh_d = 1'b0;
                    bus_write_d   = 1'b0;
                    bus_address_d = vdp_address;
                    bus_wdata_d   = '0;
                    vdp_ready_d   = 1'b1;
                    owner_cpu_d   = 1'b0;
                    if (cpu_valid && (wait_cnt_q != WC_W'(CPU_MAX_WAIT))) begin
                        wait_cnt_d = wait_cnt_q + 1'b1;
                    end
                end else if (grant_cpu) begin
                    state_d       = ST_ISSUE;
                    bus_valid_d   = 1'b1;
                    bus_refresh_d = 1'b0;
                    bus_write_d   = cpu_write;
                    bus_address_d = cpu_address;
                    bus_wdata_d   = cpu_wdata;
                    cpu_ready_d   = 1'b1;
                    owner_cpu_d   = 1'b1;
                    wait_cnt_d    = '0;
                end
            end
            ST_ISSUE: begin
                if (bus_ready) begin
                    bus_valid_d   = 1'b0;
                    bus_write_d   = 1'b0;
                    bus_refresh_d = 1'b0;
                    to_cnt_d      = '0;
                    state_d       = (bus_write_q || bus_refresh_q) ? ST_IDLE : ST_RDWAIT;
                end
            end
            ST_RDWAIT: begin
                if (bus_rdata_en) begin
                    state_d = ST_IDLE;
                    if (owner_cpu_q) begin
                        cpu_rdata_d    = bus_rdata;
                        cpu_rdata_en_d = 1'b1;
                    end else begin
                        vdp_rdata_d    = bus_rdata;
                        vdp_rdata_en_d = 1'b1;
                    end
                end else if (to_cnt_q == TO_W'(RD_TIMEOUT - 1)) begin
                    // Controller never answered: complete with all-ones so the client does not hang.
                    state_d = ST_IDLE;
                    if (owner_cpu_q) begin
                        cpu_rdata_d    = 16'hFFFF;
                        cpu_rdata_en_d = 1'b1;
                    end else begin
                        vdp_rdata_d    = 16'hFFFF;
                        vdp_rdata_en_d = 1'b1;
                    end
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_INIT;
            ref_cnt_q      <= RC_W'(REFRESH_INTERVAL - 1);
            ref_pend_q     <= '0;
            wait_cnt_q     <= '0;
            to_cnt_q       <= '0;
            owner_cpu_q    <= 1'b0;
            bus_address_q  <= '0;
            bus_valid_q    <= 1'b0;
            bus_write_q    <= 1'b0;
            bus_refresh_q  <= 1'b0;
            bus_wdata_q    <= '0;
            vdp_ready_q    <= 1'b0;
            cpu_ready_q    <= 1'b0;
            vdp_rdata_q    <= '0;
            vdp_rdata_en_q <= 1'b0;
            cpu_rdata_q    <= '0;
            cpu_rdata_en_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            ref_cnt_q      <= ref_cnt_d;
            ref_pend_q     <= ref_pend_d;
            wait_cnt_q     <= wait_cnt_d;
            to_cnt_q       <= to_cnt_d;
            owner_cpu_q    <= owner_cpu_d;
            bus_address_q  <= bus_address_d;
            bus_valid_q    <= bus_valid_d;
            bus_write_q    <= bus_write_d;
            bus_refresh_q  <= bus_refresh_d;
            bus_wdata_q    <= bus_wdata_d;
            vdp_ready_q    <= vdp_ready_d;
            cpu_ready_q    <= cpu_ready_d;
            vdp_rdata_q    <= vdp_rdata_d;
            vdp_rdata_en_q <= vdp_rdata_en_d;
            cpu_rdata_q    <= cpu_rdata_d;
            cpu_rdata_en_q <= cpu_rdata_en_d;
        end
    end

    assign vdp_ready    = vdp_ready_q;
    assign vdp_rdata    = vdp_rdata_q;
    assign vdp_rdata_en = vdp_rdata_en_q;
    assign cpu_ready    = cpu_ready_q;
    assign cpu_rdata    = cpu_rdata_q;
    assign cpu_rdata_en = cpu_rdata_en_q;
    assign bus_address  = bus_address_q;
    assign bus_valid    = bus_valid_q;
    assign bus_write    = bus_write_q;
    assign bus_refresh  = bus_refresh_q;
    assign bus_wdata    = bus_wdata_q;

endmodule

// File: tb/tb_ip_sdram_arbiter.sv
// Purpose : self-checking bench for ip_sdram_arbiter with a behavioural controller and client drivers.
// Latency : read data is scored against per-client expected queues filled when requests are driven.
// Backpres: the controller model stalls bus_ready randomly and can withhold or inject read strobes.
module tb_ip_sdram_arbiter;

    localparam int REFRESH_INTERVAL = 1280;
    localparam int RD_TIMEOUT       = 32;
    localparam int CPU_MAX_WAIT     = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sdram_init_busy;
    logic [22:0] vdp_address;
    logic        vdp_valid;
    logic        vdp_ready;
    logic [15:0] vdp_rdata;
    logic        vdp_rdata_en;
    logic [22:0] cpu_address;
    logic        cpu_valid;
    logic        cpu_write;
    logic [7:0]  cpu_wdata;
    logic        cpu_ready;
    logic [15:0] cpu_rdata;
    logic        cpu_rdata_en;
    logic [22:0] bus_address;
    logic        bus_valid;
    logic        bus_ready;
    logic        bus_write;
    logic        bus_refresh;
    logic [7:0]  bus_wdata;
    logic [15:0] bus_rdata;
    logic        bus_rdata_en;

    always #5 clk = ~clk;

    ip_sdram_arbiter #(
        .REFRESH_INTERVAL(REFRESH_INTERVAL),
        .RD_TIMEOUT(RD_TIMEOUT),
        .CPU_MAX_WAIT(CPU_MAX_WAIT)
    ) dut (
        .clk(clk), .reset_n(reset_n), .sdram_init_busy(sdram_init_busy),
        .vdp_address(vdp_address), .vdp_valid(vdp_valid), .vdp_ready(vdp_ready),
        .vdp_rdata(vdp_rdata), .vdp_rdata_en(vdp_rdata_en),
        .cpu_address(cpu_address), .cpu_valid(cpu_valid), .cpu_write(cpu_write),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
        .cpu_rdata_en(cpu_rdata_en),
        .bus_address(bus_address), .bus_valid(bus_valid), .bus_ready(bus_ready),
        .bus_write(bus_write), .bus_refresh(bus_refresh), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_rdata_en(bus_rdata_en)
    );

    int vectors     = 0;
    int miscompares = 0;

    // kind: 0 read, 1 write, 2 refresh
    typedef struct {
        int          kind;
        logic [22:0] addr;
        logic [7:0]  wdata;
    } txn_t;

    txn_t        log_q[$];
    logic [15:0] vdp_q[$];
    logic [15:0] cpu_q[$];
    logic [7:0]  shadow[int];
    logic [7:0]  mem[int];
    int          vdp_en_cnt = 0;
    int          cpu_en_cnt = 0;
    int          stable_err = 0;
    bit          stall    = 1'b0;
    bit          withhold = 1'b0;
    bit          stray    = 1'b0;

    function automatic logic [7:0] def_byte(input logic [22:0] a);
        return a[7:0] + 8'h32;
    endfunction

    function automatic logic [7:0] sh_byte(input logic [22:0] a);
        if (shadow.exists(int'(a))) return shadow[int'(a)];
        return def_byte(a);
    endfunction

    function automatic logic [7:0] mem_byte(input logic [22:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return def_byte(a);
    endfunction

    function automatic logic [15:0] word_of(input logic [22:0] a);
        logic [22:0] ev;
        ev = {a[22:1], 1'b0};
        return {sh_byte(ev | 23'd1), sh_byte(ev)};
    endfunction

    // Controller model: random bus_ready, write storage, delayed read return.
    initial begin : controller
        logic        p_valid, p_write, p_refresh;
        logic [22:0] p_addr, rd_addr, ev;
        logic [7:0]  p_wdata;
        int          rd_wait;
        txn_t        t;
        p_valid = 0; p_write = 0; p_refresh = 0; p_addr = '0; p_wdata = '0;
        rd_addr = '0; rd_wait = 0;
        bus_ready = 1'b0; bus_rdata_en = 1'b0; bus_rdata = '0;
        forever begin
            @(negedge clk);
            bus_rdata_en = 1'b0;
            if (bus_ready && p_valid) begin
                t.kind  = p_refresh ? 2 : (p_write ? 1 : 0);
                t.addr  = p_addr;
                t.wdata = p_wdata;
                log_q.push_back(t);
                if (t.kind == 1) mem[int'(p_addr)] = p_wdata;
                if (t.kind == 0 && !withhold) begin
                    rd_wait = $urandom_range(1, 4);
                    rd_addr = p_addr;
                end
            end else if (rd_wait > 0) begin
                rd_wait--;
                if (rd_wait == 0) begin
                    ev           = {rd_addr[22:1], 1'b0};
                    bus_rdata    = {mem_byte(ev | 23'd1), mem_byte(ev)};
                    bus_rdata_en = 1'b1;
                end
            end
            if (stray) begin
                bus_rdata    = 16'hDEAD;
                bus_rdata_en = 1'b1;
                stray        = 1'b0;
            end
            if (p_valid && bus_valid && !bus_ready &&
                (bus_address !== p_addr || bus_write !== p_write ||
                 bus_refresh !== p_refresh || bus_wdata !== p_wdata)) begin
                stable_err++;
            end
            p_valid   = bus_valid;
            p_addr    = bus_address;
            p_write   = bus_write;
            p_refresh = bus_refresh;
            p_wdata   = bus_wdata;
            bus_ready = bus_valid && !stall && ($urandom_range(0, 2) != 0);
        end
    end

    // Read-return scoreboard.
    initial begin : monitor
        logic [15:0] e;
        forever begin
            @(negedge clk);
            if (vdp_rdata_en) begin
                vdp_en_cnt++;
                vectors++;
                if (vdp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL vdp_unexpected_strobe: got rdata_en=1 rdata=%h, required no strobe", vdp_rdata);
                end else begin
                    e = vdp_q.pop_front();
                    if (vdp_rdata !== e) begin
                        miscompares++;
                        $display("FAIL vdp_rdata: got %h, required %h", vdp_rdata, e);
                    end
                end
            end
            if (cpu_rdata_en) begin
                cpu_en_cnt++;
                vectors++;
                if (cpu_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL cpu_unexpected_strobe: got rdata_en=1 rdata=%h, required no strobe", cpu_rdata);
                end else begin
                    e = cpu_q.pop_front();
                    if (cpu_rdata !== e) begin
                        miscompares++;
                        $display("FAIL cpu_rdata: got %h, required %h", cpu_rdata, e);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // mode 0: expect word from bench memory, 1: expect timeout value, 2: no return expected
    task automatic vdp_req(input logic [22:0] a, input bit hold, input int mode);
        int n;
        if (mode == 0) vdp_q.push_back(word_of(a));
        else if (mode == 1) vdp_q.push_back(16'hFFFF);
        vdp_address = a;
        vdp_valid   = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!vdp_ready && n < 400);
        vectors++;
        if (!vdp_ready) begin
            miscompares++;
            $display("FAIL vdp_ready_timeout: got no ready in %0d cycles, required ready", n);
        end
        if (!hold) vdp_valid = 1'b0;
    endtask

    task automatic cpu_req(input logic [22:0] a, input bit w, input logic [7:0] d, input bit hold);
        int n;
        if (w) shadow[int'(a)] = d;
        else cpu_q.push_back(word_of(a));
        cpu_address = a;
        cpu_write   = w;
        cpu_wdata   = d;
        cpu_valid   = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_ready && n < 400);
        vectors++;
        if (!cpu_ready) begin
            miscompares++;
            $display("FAIL cpu_ready_timeout: got no ready in %0d cycles, required ready", n);
        end
        if (!hold) cpu_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((vdp_q.size() != 0 || cpu_q.size() != 0 || bus_valid) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (8) @(negedge clk);
        vectors++;
        if (n >= 3000) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d vdp/%0d cpu outstanding, required 0", vdp_q.size(), cpu_q.size());
        end
    endtask

    task automatic test_reset();
        reset_n = 1'b0; sdram_init_busy = 1'b1;
        vdp_valid = 1'b0; vdp_address = '0;
        cpu_valid = 1'b0; cpu_address = '0; cpu_write = 1'b0; cpu_wdata = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({vdp_ready, vdp_rdata, vdp_rdata_en, cpu_ready, cpu_rdata, cpu_rdata_en,
             bus_address, bus_valid, bus_write, bus_refresh, bus_wdata} !== 70'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got bus_valid=%b vdp_ready=%b cpu_ready=%b, required all 0",
                     bus_valid, vdp_ready, cpu_ready);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_init();
        int bad, n;
        bad = 0;
        vdp_q.push_back(word_of(23'h100010));
        vdp_address = 23'h100010;
        vdp_valid   = 1'b1;
        repeat (200) begin
            @(negedge clk);
            if (bus_valid || vdp_ready) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL init_quiet: got %0d active cycles during init, required 0", bad);
        end
        sdram_init_busy = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!vdp_ready && n < 20);
        vectors++;
        if (!vdp_ready) begin
            miscompares++;
            $display("FAIL init_release: got no vdp_ready after init, required ready");
        end
        vdp_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_write_read();
        int nw, c0;
        log_q.delete();
        c0 = cpu_en_cnt;
        cpu_req(23'h000003, 1'b1, 8'h45, 1'b0);
        cpu_req(23'h000002, 1'b0, 8'h00, 1'b0);
        // replace the model-derived expectation with the literal documented word
        if (cpu_q.size() == 1) begin
            void'(cpu_q.pop_back());
            cpu_q.push_back(16'h4534);
        end
        wait_idle();
        nw = 0;
        foreach (log_q[i]) if (log_q[i].kind == 1) nw++;
        vectors++;
        if (nw != 1) begin
            miscompares++;
            $display("FAIL write_count: got %0d bus writes, required 1", nw);
        end
        vectors++;
        if (cpu_en_cnt - c0 != 1) begin
            miscompares++;
            $display("FAIL cpu_strobe_count: got %0d strobes, required 1", cpu_en_cnt - c0);
        end
        foreach (log_q[i]) if (log_q[i].kind == 1) begin
            vectors++;
            if (log_q[i].addr !== 23'h000003 || log_q[i].wdata !== 8'h45) begin
                miscompares++;
                $display("FAIL write_fields: got addr %h data %h, required 000003/45", log_q[i].addr, log_q[i].wdata);
            end
        end
    endtask

    task automatic test_arbitration();
        txn_t seq[$];
        bit   exp_cpu;
        log_q.delete();
        fork
            begin
                for (int i = 0; i < 9; i++) vdp_req(23'h100000 + 23'(4 * i), (i != 8), 0);
            end
            begin
                cpu_req(23'h000200, 1'b0, 8'h00, 1'b1);
                cpu_req(23'h000204, 1'b0, 8'h00, 1'b0);
            end
        join
        wait_idle();
        foreach (log_q[i]) if (log_q[i].kind != 2) seq.push_back(log_q[i]);
        vectors++;
        if (seq.size() != 11) begin
            miscompares++;
            $display("FAIL arb_count: got %0d client transactions, required 11", seq.size());
        end else begin
            for (int i = 0; i < 11; i++) begin
                exp_cpu = (i == 4) || (i == 9);
                vectors++;
                if ((seq[i].addr < 23'h100000) !== exp_cpu || seq[i].kind != 0) begin
                    miscompares++;
                    $display("FAIL arb_order[%0d]: got addr %h kind %0d, required %s read",
                             i, seq[i].addr, seq[i].kind, exp_cpu ? "cpu" : "vdp");
                end
            end
        end
    endtask

    task automatic test_refresh();
        int n;
        stall = 1'b1;
        n = 0;
        while (!bus_refresh && n < REFRESH_INTERVAL + 100) begin @(negedge clk); n++; end
        vectors++;
        if (!(bus_refresh && bus_valid && !bus_write && bus_address == 23'd0)) begin
            miscompares++;
            $display("FAIL refresh_cmd: got refresh=%b valid=%b write=%b addr=%h, required 1/1/0/0",
                     bus_refresh, bus_valid, bus_write, bus_address);
        end
        repeat (3 * REFRESH_INTERVAL) @(negedge clk);
        log_q.delete();
        vdp_q.push_back(word_of(23'h100100));
        vdp_address = 23'h100100;
        vdp_valid   = 1'b1;
        stall       = 1'b0;
        n = 0;
        do begin @(negedge clk); n++; end while (!vdp_ready && n < 100);
        vdp_valid = 1'b0;
        wait_idle();
        repeat (20) @(negedge clk);
        vectors++;
        if (log_q.size() < 4) begin
            miscompares++;
            $display("FAIL refresh_drain: got %0d transactions, required at least 4", log_q.size());
        end else begin
            vectors++;
            if (log_q[0].kind != 2 || log_q[1].kind != 2 || log_q[2].kind != 0 ||
                log_q[2].addr !== 23'h100100 || log_q[3].kind != 2) begin
                miscompares++;
                $display("FAIL refresh_order: got kinds %0d %0d %0d %0d, required 2 2 0 2",
                         log_q[0].kind, log_q[1].kind, log_q[2].kind, log_q[3].kind);
            end
        end
    endtask

    task automatic test_timeout();
        int n;
        withhold = 1'b1;
        vdp_req(23'h100200, 1'b0, 1);
        n = 0;
        while (!vdp_rdata_en && n < RD_TIMEOUT + 20) begin @(negedge clk); n++; end
        vectors++;
        if (!vdp_rdata_en || n < RD_TIMEOUT || n > RD_TIMEOUT + 10) begin
            miscompares++;
            $display("FAIL timeout_latency: got strobe after %0d cycles, required %0d..%0d",
                     n, RD_TIMEOUT, RD_TIMEOUT + 10);
        end
        withhold = 1'b0;
        repeat (3) @(negedge clk);
        stray = 1'b1;   // strobe while idle must be ignored
        repeat (5) @(negedge clk);
        cpu_req(23'h000010, 1'b0, 8'h00, 1'b0);
        wait_idle();
    endtask

    task automatic test_reset_rdwait();
        int n, v0;
        withhold = 1'b1;
        vdp_req(23'h100300, 1'b0, 2);
        n = 0;
        while (bus_valid && n < 100) begin @(negedge clk); n++; end
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        vectors++;
        if ({vdp_ready, vdp_rdata, vdp_rdata_en, cpu_ready, cpu_rdata, cpu_rdata_en,
             bus_address, bus_valid, bus_write, bus_refresh, bus_wdata} !== 70'd0) begin
            miscompares++;
            $display("FAIL reset_rdwait_outputs: got vdp_rdata=%h bus_valid=%b, required all 0", vdp_rdata, bus_valid);
        end
        reset_n  = 1'b1;
        withhold = 1'b0;
        v0 = vdp_en_cnt;
        stray = 1'b1;
        repeat (10) @(negedge clk);
        vectors++;
        if (vdp_en_cnt != v0) begin
            miscompares++;
            $display("FAIL reset_late_strobe: got %0d vdp strobes, required 0", vdp_en_cnt - v0);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] d;
        for (int i = 0; i < 4; i++) begin
            d = 8'($urandom_range(0, 255));
            cpu_req(23'h100400 + 23'(i), 1'b1, d, 1'b1);
        end
        for (int i = 0; i < 4; i += 2) cpu_req(23'h100400 + 23'(i), 1'b0, 8'h00, (i != 2));
        vdp_req(23'h100401, 1'b1, 0);
        vdp_req(23'h100402, 1'b0, 0);
        wait_idle();
        vectors++;
        if (stable_err != 0) begin
            miscompares++;
            $display("FAIL bus_stability: got %0d unstable issue cycles, required 0", stable_err);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_write_read();
        test_arbitration();
        test_refresh();
        test_timeout();
        test_reset_rdwait();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
